// File: rtl/calc_fsm_bcd_if.sv
// Keypad-to-display bus of the calculator core: key code and press level in,
// BCD display digits plus sign/error/busy flags out.
interface calc_fsm_bcd_if #(parameter int N_DIGITS = 4);
    logic [7:0]            key;
    logic                  pressed;
    logic [4*N_DIGITS-1:0] digits;
    logic                  neg;
    logic                  err;
    logic                  busy;

    modport master (output key, pressed, input digits, neg, err, busy);
    modport slave  (input key, pressed, output digits, neg, err, busy);
endinterface

// File: rtl/calc_fsm_bcd.sv
// Keypad calculator core: operand entry, signed add/sub/mul with chaining,
// overflow trap and a sequential double-dabble binary-to-BCD display converter.
module calc_fsm_bcd #(
    parameter int N_DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    calc_fsm_bcd_if.slave bus
);
    localparam int W   = $clog2(10**N_DIGITS);
    localparam int DW  = 4*N_DIGITS;
    localparam int NCW = $clog2(N_DIGITS+1);
    localparam int CW  = $clog2(W+2);
    localparam logic [2*W:0] MAXV = (2*W+1)'(10**N_DIGITS - 1);

    typedef enum logic [2:0] {S_ENTER_A, S_ENTER_B, S_CONVERT, S_RESULT, S_ERROR} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

    state_t                   r_state;
    op_t                      r_op;
    logic [W-1:0]             r_a_mag;
    logic                     r_a_neg;
    logic [W-1:0]             r_b;
    logic [NCW-1:0]           r_a_cnt;
    logic [NCW-1:0]           r_b_cnt;
    logic [DW-1:0]            r_digits;
    logic [W-1:0]             r_bin;
    logic [N_DIGITS-1:0][3:0] r_bcd;
    logic [CW-1:0]            r_cnt;
    logic                     r_chain;
    logic                     r_neg;
    logic                     r_err;
    logic                     r_busy;
    logic                     r_prev;

    // Key decode; key[7] outranks key[6], which outranks a digit.
    logic       w_press, w_clr, w_arith, w_eq, w_dig, w_calc;
    logic [3:0] w_d;
    op_t        w_new_op;
    logic       w_unused;

    assign w_press  = bus.pressed & ~r_prev;
    assign w_arith  = bus.key[7] && (bus.key[2:0] inside {3'd1, 3'd2, 3'd3});
    assign w_clr    = bus.key[7] && (bus.key[2:0] == 3'd4);
    assign w_eq     = !bus.key[7] && bus.key[6];
    assign w_dig    = (bus.key[7:6] == 2'b00) && (bus.key[3:0] <= 4'd9);
    assign w_d      = bus.key[3:0];
    assign w_unused = &{1'b0, bus.key[5:4]};

    always_comb begin
        case (bus.key[1:0])
            2'd2:    w_new_op = OP_SUB;
            2'd3:    w_new_op = OP_MUL;
            default: w_new_op = OP_ADD;
        endcase
    end

    // An operator only chains once B has a significant digit.
    assign w_calc = w_press && (r_state == S_ENTER_B) &&
                    ((w_arith && r_b_cnt != '0) || w_eq);

    logic signed [2*W:0] w_a, w_bs, w_res;
    logic        [2*W:0] w_abs;
    logic                w_ovf;

    always_comb begin
        w_a  = signed'({{(W+1){1'b0}}, r_a_mag});
        if (r_a_neg) w_a = -w_a;
        w_bs = signed'({{(W+1){1'b0}}, r_b});
        case (r_op)
            OP_SUB:  w_res = w_a - w_bs;
            OP_MUL:  w_res = w_a * w_bs;
            default: w_res = w_a + w_bs;
        endcase
        w_abs = w_res[2*W] ? unsigned'(-w_res) : unsigned'(w_res);
        w_ovf = w_abs > MAXV;
    end

    // Operand entry; a digit in RESULT starts a fresh A from zero.
    logic [W-1:0]   w_base, w_opnd_nx;
    logic [NCW-1:0] w_cnt, w_cnt_nx;
    logic           w_dig_ok;
    logic [DW-1:0]  w_disp_nx;

    always_comb begin
        w_base = r_a_mag;
        w_cnt  = r_a_cnt;
        if (r_state == S_ENTER_B) begin
            w_base = r_b;
            w_cnt  = r_b_cnt;
        end else if (r_state == S_RESULT) begin
            w_base = '0;
            w_cnt  = '0;
        end
    end

    assign w_opnd_nx = w_base * W'(10) + W'(w_d);
    assign w_cnt_nx  = (w_cnt == '0 && w_d == 4'd0) ? '0 : w_cnt + NCW'(1);
    assign w_dig_ok  = w_cnt < NCW'(N_DIGITS);
    assign w_disp_nx = (w_cnt == '0) ? DW'(w_d) : ((r_digits << 4) | DW'(w_d));

    logic [N_DIGITS-1:0][3:0] w_bcd_adj;
    logic [DW+W-1:0]          w_dd;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dab
        assign w_bcd_adj[g] = (r_bcd[g] >= 4'd5) ? r_bcd[g] + 4'd3 : r_bcd[g];
    end
    assign w_dd = {w_bcd_adj, r_bin} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_ENTER_A;
            r_op     <= OP_ADD;
            r_a_mag  <= '0;
            r_a_neg  <= 1'b0;
            r_b      <= '0;
            r_a_cnt  <= '0;
            r_b_cnt  <= '0;
            r_digits <= '0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_chain  <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_prev   <= 1'b0;
        end else begin
            r_prev <= bus.pressed;
            if (w_press && w_clr) begin
                r_state  <= S_ENTER_A;
                r_op     <= OP_ADD;
                r_a_mag  <= '0;
                r_a_neg  <= 1'b0;
                r_b      <= '0;
                r_a_cnt  <= '0;
                r_b_cnt  <= '0;
                r_digits <= '0;
                r_bin    <= '0;
                r_bcd    <= '0;
                r_cnt    <= '0;
                r_chain  <= 1'b0;
                r_neg    <= 1'b0;
                r_err    <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_calc) begin
                if (w_ovf) begin
                    r_err    <= 1'b1;
                    r_neg    <= 1'b0;
                    r_digits <= '1;
                    r_state  <= S_ERROR;
                end else begin
                    r_a_mag <= w_abs[W-1:0];
                    r_a_neg <= w_res[2*W];
                    r_neg   <= w_res[2*W];
                    r_bin   <= w_abs[W-1:0];
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_chain <= w_arith;
                    if (w_arith) r_op <= w_new_op;
                    r_state <= S_CONVERT;
                end
            end else begin
                case (r_state)
                    S_ENTER_A, S_ENTER_B, S_RESULT: begin
                        if (w_press && w_arith) begin
                            r_op <= w_new_op;
                            if (r_state != S_ENTER_B) begin
                                r_b     <= '0;
                                r_b_cnt <= '0;
                                r_state <= S_ENTER_B;
                            end
                        end else if (w_press && !w_eq && w_dig && w_dig_ok) begin
                            if (r_state == S_ENTER_B) begin
                                r_b     <= w_opnd_nx;
                                r_b_cnt <= w_cnt_nx;
                            end else begin
                                r_a_mag <= w_opnd_nx;
                                r_a_cnt <= w_cnt_nx;
                                r_a_neg <= 1'b0;
                            end
                            if (r_state == S_RESULT) begin
                                r_neg   <= 1'b0;
                                r_state <= S_ENTER_A;
                            end
                            r_digits <= w_disp_nx;
                        end
                    end
                    // One settle cycle, W shift cycles under busy, then the load.
                    S_CONVERT: begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(1)) r_busy <= 1'b1;
                        if (r_cnt >= CW'(1) && r_cnt <= CW'(W)) begin
                            r_bcd <= w_dd[DW+W-1:W];
                            r_bin <= w_dd[W-1:0];
                        end
                        if (r_cnt == CW'(W+1)) begin
                            r_digits <= r_bcd;
                            r_busy   <= 1'b0;
                            if (r_chain) begin
                                r_b     <= '0;
                                r_b_cnt <= '0;
                                r_state <= S_ENTER_B;
                            end else begin
                                r_state <= S_RESULT;
                            end
                        end
                    end
                    S_ERROR: ;
                    default: r_state <= S_ENTER_A;
                endcase
            end
        end
    end

    assign bus.digits = r_digits;
    assign bus.neg    = r_neg;
    assign bus.err    = r_err;
    assign bus.busy   = r_busy;
endmodule
